r_alloc: RTL and testbench
==========================

Name: r_alloc

Overview:
- Circular slot allocator built around the circular find-first-zero search, extended with state.
- Holds a W-bit busy vector and a search pointer. Each cycle it offers the first free slot found by a circular search that starts below the pointer.
- Offers are consumed through a valid/ack handshake; slots are returned through a free port.
- Used by tag, ID and buffer-entry managers that need fair, rotating reuse of slots.

Parameters:
- W, 32, number of slots; power of two, >= 4.
- NEXT_FIT, 1'b1, 1: pointer follows the last allocated slot (rotating reuse). 0: pointer fixed at 0 (static priority, highest index first).
- INFER, 1'b1, 1: inferred rotators. 0: explicit bs rotators.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- alloc_vld_o  out  1  a free slot is offered this cycle.
- alloc_id_o  out  $clog2(W)  encoded offered slot.
- alloc_oh_o  out  W  one-hot offered slot.
- alloc_ack_i  in  1  consumer takes the offered slot.
- free_vld_i  in  1  return a slot.
- free_id_i  in  $clog2(W)  slot being returned.
- busy_o  out  W  registered busy vector.
- cnt_o  out  $clog2(W)+1  number of busy slots.
- full_o  out  1  all slots busy.
- empty_o  out  1  no slots busy.
- err_o  out  1  sticky: a free was issued to a non-busy slot.

Behaviour:
- Clocking and reset: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- Reset values: busy = 0, ptr = 0, cnt_o = 0, err_o = 0. Outputs therefore read alloc_vld_o = 1, alloc_id_o = W-1, alloc_oh_o = 1<<(W-1), full_o = 0, empty_o = 1.
- While rst_i = 1, alloc_ack_i and free_vld_i are ignored; reset takes priority over every update in that cycle.
- Search order: slots ptr-1, ptr-2, ..., 0, W-1, ..., ptr, modulo W. The pointer slot itself is checked last. The first non-busy slot is offered.
- Search implementation: rotate busy left by (W-ptr) mod W, invert, priority-detect from MSB, rotate right by the same amount, encode.
- Offer outputs (alloc_*) are combinational from registered state only, never from same-cycle free_vld_i.
- alloc_vld_o = ~full_o. When alloc_vld_o = 0, alloc_id_o and alloc_oh_o are don't-care and must not be checked.
- Handshake: a transfer occurs on a rising edge with alloc_vld_o & alloc_ack_i.
  - The slot's busy bit is set on that edge.
  - If NEXT_FIT = 1, ptr <= alloc_id_o.
  - alloc_ack_i while alloc_vld_o = 0 has no effect.
- Free handling: on an edge with free_vld_i, if busy[free_id_i] = 1 it is cleared. Otherwise busy is unchanged and err_o <= 1. err_o stays set until reset.
- Simultaneous alloc and free:
  - Both apply on the same edge; cnt_o is unchanged.
  - The freed slot becomes offerable from the next cycle.
  - A free of the slot being offered in that cycle is a double-free: err_o is set and the alloc still marks the slot busy.
- Counter: cnt_o = cnt + transfer - valid_free, registered.
  - full_o = (cnt_o == W) and empty_o = (cnt_o == 0), both derived from registered cnt.
  - cnt_o always equals popcount(busy_o); this is an assertion target.
- Latency: an allocation is visible on busy_o and cnt_o 1 cycle after the ack edge. A free is visible 1 cycle after its edge.
- Pointer: ptr is $clog2(W) bits and wraps naturally. If NEXT_FIT = 0, ptr stays at 0 permanently.
- Reset mid-operation: all state clears on the reset edge, and any in-flight ack or free in that cycle is dropped.

Test Plan:
- W=16, NEXT_FIT=1, after reset hold alloc_ack_i=1 for 16 cycles -> ids 15,14,...,0 in order; then full_o=1, alloc_vld_o=0, cnt_o=16, busy_o=16'hFFFF.
- From full with ptr=0: free 5, next cycle free 9 -> offer 9 (search starts at 15, descending). Ack -> ptr=9, next offer 5. Ack -> full again.
- Wrap-around: full with ptr=0; free 2, ack (ptr=2); free 7 -> search order 1,0,15..8,7 -> offer 7, alloc_oh_o=16'h0080.
- Simultaneous: cnt_o=3, ack on slot 12 plus free of busy slot 4 in the same cycle -> cnt_o stays 3, bit 12 set, bit 4 clear. Slot 4 is not offered in that cycle but is offerable from the next cycle if first in search order.
- Double free: after reset, free_id_i=3 -> err_o=1 next cycle, busy_o unchanged. err_o stays 1 through further traffic; asserting rst_i clears it.
- NEXT_FIT=0: alloc 15, free 15 -> offer 15 again (NEXT_FIT=1 would offer 14). Repeat with INFER=0; results must be identical.

Source files
------------

// File: rtl/r_alloc.sv
// rtl/r_alloc.sv - circular slot allocator with busy vector, search pointer and alloc/free ports
// Offers the first free slot below the pointer, wrapping; returns slots through the free port.

module r_alloc_rot #(
   parameter int   W      = 32,
   parameter bit   LEFT   = 1'b1,
   parameter bit   INFER  = 1'b1,
   localparam int  IW     = $clog2(W)
) (
   input  logic [W-1:0]  i_data,
   input  logic [IW-1:0] i_amt,
   output logic [W-1:0]  o_data
);

   generate
      if (INFER) begin : g_infer
         logic [2*W-1:0] w_dbl;
         if (LEFT) begin : g_left
            assign w_dbl  = {i_data, i_data} << i_amt;
            assign o_data = w_dbl[2*W-1:W];
         end else begin : g_right
            assign w_dbl  = {i_data, i_data} >> i_amt;
            assign o_data = w_dbl[W-1:0];
         end
      end else begin : g_bs
         // log2(W) stages, stage s rotates by 2**s when amount bit s is set
         logic [W-1:0] w_st [IW+1];
         assign w_st[0] = i_data;
         for (genvar s = 0; s < IW; s++) begin : g_stage
            localparam int SH = 1 << s;
            if (LEFT) begin : g_left
               assign w_st[s+1] = i_amt[s] ? {w_st[s][W-1-SH:0], w_st[s][W-1:W-SH]} : w_st[s];
            end else begin : g_right
               assign w_st[s+1] = i_amt[s] ? {w_st[s][SH-1:0], w_st[s][W-1:SH]} : w_st[s];
            end
         end
         assign o_data = w_st[IW];
      end
   endgenerate

endmodule

module r_alloc #(
   parameter int  W        = 32,
   parameter bit  NEXT_FIT = 1'b1,
   parameter bit  INFER    = 1'b1,
   localparam int IW       = $clog2(W),
   localparam int CW       = IW + 1
) (
   input  logic          clk_i,
   input  logic          rst_i,
   output logic          alloc_vld_o,
   output logic [IW-1:0] alloc_id_o,
   output logic [W-1:0]  alloc_oh_o,
   input  logic          alloc_ack_i,
   input  logic          free_vld_i,
   input  logic [IW-1:0] free_id_i,
   output logic [W-1:0]  busy_o,
   output logic [CW-1:0] cnt_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          err_o
);

   logic [W-1:0]  r_busy;
   logic [IW-1:0] r_ptr;
   logic [CW-1:0] r_cnt;
   logic          r_err;

   logic [IW-1:0] w_amt;
   logic [W-1:0]  w_busy_rot;
   logic [W-1:0]  w_free_rot;
   logic [W-1:0]  w_pick_rot;
   logic [W-1:0]  w_oh;
   logic [IW-1:0] w_id;
   logic          w_found;
   logic          w_full;
   logic          w_xfer;
   logic          w_free_ok;
   logic          w_free_bad;
   logic [W-1:0]  w_set_mask;
   logic [W-1:0]  w_clr_mask;
   logic [W-1:0]  w_busy_nxt;
   logic [CW-1:0] w_cnt_nxt;

   // Rotating left by (W-ptr) puts slot ptr-1 at the MSB and slot ptr at the LSB
   assign w_amt = IW'(0) - r_ptr;

   r_alloc_rot #(.W(W), .LEFT(1'b1), .INFER(INFER)) u_rot_l (
      .i_data (r_busy),
      .i_amt  (w_amt),
      .o_data (w_busy_rot)
   );

   assign w_free_rot = ~w_busy_rot;

   always_comb begin
      w_pick_rot = '0;
      w_found    = 1'b0;
      for (int i = W - 1; i >= 0; i--) begin
         if (w_free_rot[i] && !w_found) begin
            w_pick_rot[i] = 1'b1;
            w_found       = 1'b1;
         end
      end
   end

   r_alloc_rot #(.W(W), .LEFT(1'b0), .INFER(INFER)) u_rot_r (
      .i_data (w_pick_rot),
      .i_amt  (w_amt),
      .o_data (w_oh)
   );

   always_comb begin
      w_id = '0;
      for (int i = 0; i < W; i++) begin
         if (w_oh[i]) begin
            w_id = w_id | IW'(i);
         end
      end
   end

   assign w_full      = (r_cnt == CW'(W));
   assign alloc_vld_o = ~w_full;
   assign alloc_id_o  = w_id;
   assign alloc_oh_o  = w_oh;

   // An offered slot is never busy, so a free aimed at it always lands in w_free_bad
   assign w_xfer     = alloc_vld_o & alloc_ack_i;
   assign w_free_ok  = free_vld_i & r_busy[free_id_i];
   assign w_free_bad = free_vld_i & ~r_busy[free_id_i];
   assign w_set_mask = w_xfer ? w_oh : '0;
   assign w_clr_mask = w_free_ok ? (W'(1) << free_id_i) : '0;
   assign w_busy_nxt = (r_busy | w_set_mask) & ~w_clr_mask;
   assign w_cnt_nxt  = r_cnt + CW'(w_xfer) - CW'(w_free_ok);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_busy <= '0;
         r_ptr  <= '0;
         r_cnt  <= '0;
         r_err  <= 1'b0;
      end else begin
         r_busy <= w_busy_nxt;
         r_cnt  <= w_cnt_nxt;
         if (w_xfer && NEXT_FIT) begin
            r_ptr <= w_id;
         end
         if (w_free_bad) begin
            r_err <= 1'b1;
         end
      end
   end

   assign busy_o  = r_busy;
   assign cnt_o   = r_cnt;
   assign full_o  = w_full;
   assign empty_o = (r_cnt == '0);
   assign err_o   = r_err;

endmodule

// File: tb/tb_r_alloc.sv
// tb/tb_r_alloc.sv - directed bench for r_alloc, W=16
// Instances 0/1 are next-fit (inferred/explicit rotators), 2/3 are static priority.

module tb_r_alloc;

   localparam int S_VLD   = 0;
   localparam int S_ID    = 1;
   localparam int S_OH    = 2;
   localparam int S_BUSY  = 3;
   localparam int S_CNT   = 4;
   localparam int S_FULL  = 5;
   localparam int S_EMPTY = 6;
   localparam int S_ERR   = 7;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ack [4];
   logic        fvld [4];
   logic [3:0]  fid [4];
   logic        vld [4];
   logic [3:0]  id [4];
   logic [15:0] oh [4];
   logic [15:0] busy [4];
   logic [4:0]  cnt [4];
   logic        full [4];
   logic        empty [4];
   logic        err [4];

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      r_alloc #(
         .W        (16),
         .NEXT_FIT ((g < 2) ? 1'b1 : 1'b0),
         .INFER    ((g % 2 == 0) ? 1'b1 : 1'b0)
      ) u_dut (
         .clk_i       (clk),
         .rst_i       (rst),
         .alloc_vld_o (vld[g]),
         .alloc_id_o  (id[g]),
         .alloc_oh_o  (oh[g]),
         .alloc_ack_i (ack[g]),
         .free_vld_i  (fvld[g]),
         .free_id_i   (fid[g]),
         .busy_o      (busy[g]),
         .cnt_o       (cnt[g]),
         .full_o      (full[g]),
         .empty_o     (empty[g]),
         .err_o       (err[g])
      );
   end

   function automatic logic [31:0] pick(input int k, input int sel);
      case (sel)
         S_VLD:   return 32'(vld[k]);
         S_ID:    return 32'(id[k]);
         S_OH:    return 32'(oh[k]);
         S_BUSY:  return 32'(busy[k]);
         S_CNT:   return 32'(cnt[k]);
         S_FULL:  return 32'(full[k]);
         S_EMPTY: return 32'(empty[k]);
         default: return 32'(err[k]);
      endcase
   endfunction

   // grp 0 = next-fit pair, grp 1 = static pair
   task automatic chk(input string tag, input int grp, input int sel, input logic [31:0] exp);
      logic [31:0] obs;
      for (int k = grp * 2; k < grp * 2 + 2; k++) begin
         obs = pick(k, sel);
         vectors++;
         assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s[u%0d] observed=%0h expected=%0h", tag, k, obs, exp);
         end
      end
   endtask

   task automatic drv(input int grp, input logic a, input logic fv, input logic [3:0] f);
      for (int k = grp * 2; k < grp * 2 + 2; k++) begin
         ack[k]  = a;
         fvld[k] = fv;
         fid[k]  = f;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      drv(0, 1'b0, 1'b0, 4'd0);
      drv(1, 1'b0, 1'b0, 4'd0);
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic fill_a();
      drv(0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) step();
      drv(0, 1'b0, 1'b0, 4'd0);
   endtask

   // cnt must track popcount(busy) on every instance at all times
   always @(negedge clk) begin
      if (!rst) begin
         for (int k = 0; k < 4; k++) begin
            vectors++;
            assert (cnt[k] === 5'($countones(busy[k]))) else begin
               miscompares++;
               $error("FAIL cnt_popcount[u%0d] observed=%0h expected=%0h", k, cnt[k], $countones(busy[k]));
            end
         end
      end
   end

   initial begin
      int e;
      int prv;
      drv(0, 1'b0, 1'b0, 4'd0);
      drv(1, 1'b0, 1'b0, 4'd0);

      // reset with ack and a non-busy free held: both must be dropped
      rst = 1'b1;
      drv(0, 1'b1, 1'b1, 4'd3);
      step();
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      rst = 1'b0;
      chk("rst_vld",   0, S_VLD,   32'd1);
      chk("rst_id",    0, S_ID,    32'd15);
      chk("rst_oh",    0, S_OH,    32'h8000);
      chk("rst_busy",  0, S_BUSY,  32'h0);
      chk("rst_cnt",   0, S_CNT,   32'd0);
      chk("rst_full",  0, S_FULL,  32'd0);
      chk("rst_empty", 0, S_EMPTY, 32'd1);
      chk("rst_err",   0, S_ERR,   32'd0);

      // fill: ids descend 15..0
      drv(0, 1'b1, 1'b0, 4'd0);
      for (int i = 0; i < 16; i++) begin
         chk("fill_id", 0, S_ID, 32'(15 - i));
         step();
      end
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("full_full", 0, S_FULL,  32'd1);
      chk("full_vld",  0, S_VLD,   32'd0);
      chk("full_cnt",  0, S_CNT,   32'd16);
      chk("full_busy", 0, S_BUSY,  32'hFFFF);
      chk("full_empty", 0, S_EMPTY, 32'd0);

      // ack while nothing is offered has no effect
      drv(0, 1'b1, 1'b0, 4'd0);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("ack_full_cnt",  0, S_CNT,  32'd16);
      chk("ack_full_busy", 0, S_BUSY, 32'hFFFF);

      // free 5 then 9 with ptr=0: 9 is found first, then 5
      drv(0, 1'b0, 1'b1, 4'd5);
      step();
      chk("free5_vld", 0, S_VLD, 32'd1);
      chk("free5_id",  0, S_ID,  32'd5);
      drv(0, 1'b0, 1'b1, 4'd9);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("free9_id",   0, S_ID,   32'd9);
      chk("free9_oh",   0, S_OH,   32'h0200);
      chk("free9_cnt",  0, S_CNT,  32'd14);
      chk("free9_busy", 0, S_BUSY, 32'hFDDF);
      drv(0, 1'b1, 1'b0, 4'd0);
      step();
      chk("after9_id", 0, S_ID, 32'd5);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("refull_full", 0, S_FULL, 32'd1);

      // wrap-around with ptr=0: free 2, take it, free 7 -> 7
      do_reset();
      fill_a();
      drv(0, 1'b0, 1'b1, 4'd2);
      step();
      chk("wrap_id2", 0, S_ID, 32'd2);
      drv(0, 1'b1, 1'b0, 4'd0);
      step();
      drv(0, 1'b0, 1'b1, 4'd7);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("wrap_id7", 0, S_ID, 32'd7);
      chk("wrap_oh7", 0, S_OH, 32'h0080);

      // rotate through the ring keeping 4 and 5 busy; ends with busy {13,5,4}, ptr=13
      do_reset();
      for (int i = 0; i < 19; i++) begin
         e   = (15 - i) & 15;
         prv = (e + 1) & 15;
         chk("rot_id", 0, S_ID, 32'(e));
         if (i > 0 && prv != 4 && prv != 5) drv(0, 1'b1, 1'b1, 4'(prv));
         else drv(0, 1'b1, 1'b0, 4'd0);
         step();
      end
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("sim_pre_cnt",  0, S_CNT,  32'd3);
      chk("sim_pre_busy", 0, S_BUSY, 32'h2030);
      chk("sim_pre_id",   0, S_ID,   32'd12);
      drv(0, 1'b1, 1'b1, 4'd4);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("sim_cnt",  0, S_CNT,  32'd3);
      chk("sim_busy", 0, S_BUSY, 32'h3020);
      chk("sim_id",   0, S_ID,   32'd11);
      chk("sim_err",  0, S_ERR,  32'd0);

      // double frees: idle slot, then the slot offered in the same cycle
      do_reset();
      drv(0, 1'b0, 1'b1, 4'd3);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("df_err",  0, S_ERR,  32'd1);
      chk("df_busy", 0, S_BUSY, 32'h0);
      chk("df_cnt",  0, S_CNT,  32'd0);
      do_reset();
      chk("df_rst_err", 0, S_ERR, 32'd0);
      drv(0, 1'b1, 1'b1, 4'd15);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("dfo_err",  0, S_ERR,  32'd1);
      chk("dfo_busy", 0, S_BUSY, 32'h8000);
      chk("dfo_cnt",  0, S_CNT,  32'd1);
      drv(0, 1'b1, 1'b0, 4'd0);
      step();
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      chk("df_sticky", 0, S_ERR,  32'd1);
      chk("df_busy3",  0, S_BUSY, 32'hE000);
      do_reset();
      chk("df_clr_err", 0, S_ERR, 32'd0);

      // alloc 15, free 15: static priority re-offers 15, next-fit offers 14
      drv(0, 1'b1, 1'b0, 4'd0);
      drv(1, 1'b1, 1'b0, 4'd0);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      drv(1, 1'b0, 1'b0, 4'd0);
      chk("nf0_alloc_busy", 1, S_BUSY, 32'h8000);
      chk("nf0_alloc_id",   1, S_ID,   32'd14);
      drv(0, 1'b0, 1'b1, 4'd15);
      drv(1, 1'b0, 1'b1, 4'd15);
      step();
      drv(0, 1'b0, 1'b0, 4'd0);
      drv(1, 1'b0, 1'b0, 4'd0);
      chk("nf0_id",    1, S_ID,    32'd15);
      chk("nf0_oh",    1, S_OH,    32'h8000);
      chk("nf0_empty", 1, S_EMPTY, 32'd1);
      chk("nf1_id",    0, S_ID,    32'd14);

      // static priority keeps offering the highest free index after several allocs
      drv(1, 1'b1, 1'b0, 4'd0);
      step();
      step();
      step();
      drv(1, 1'b0, 1'b1, 4'd14);
      step();
      drv(1, 1'b0, 1'b0, 4'd0);
      chk("nf0_multi_busy", 1, S_BUSY, 32'hA000);
      chk("nf0_multi_id",   1, S_ID,   32'd14);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
